// File: rtl/mp_pkg.sv
// Shared opcode set, instruction field layout and decode helpers for mp_pipe.
package mp_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'd1;
  localparam logic [OP_W-1:0] OP_XOR = 6'd2;
  localparam logic [OP_W-1:0] OP_OR  = 6'd3;
  localparam logic [OP_W-1:0] OP_MIN = 6'd4;
  localparam logic [OP_W-1:0] OP_AND = 6'd5;
  localparam logic [OP_W-1:0] OP_SUB = 6'd6;
  localparam logic [OP_W-1:0] OP_MAX = 6'd7;
  localparam logic [OP_W-1:0] OP_NEG = 6'd8;
  localparam logic [OP_W-1:0] OP_AVG = 6'd11;
  localparam logic [OP_W-1:0] OP_ABS = 6'd13;
  localparam logic [OP_W-1:0] OP_NOT = 6'd15;

  // rs1 always sits directly above the opcode.
  localparam int RS1_LSB = OP_W;

  function automatic logic is_defined_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_XOR, OP_OR, OP_MIN, OP_AND, OP_SUB,
      OP_MAX, OP_NEG, OP_AVG, OP_ABS, OP_NOT: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic int rs2_lsb(input int addr_w);
    return OP_W + addr_w;
  endfunction

  function automatic int rd_lsb(input int addr_w);
    return OP_W + 2 * addr_w;
  endfunction

  // First instruction bit above the rd field; bits from here up are ignored.
  function automatic int field_end(input int addr_w);
    return OP_W + 3 * addr_w;
  endfunction

endpackage

// File: rtl/mp_alu_p.sv
// Combinational ALU: signed two's-complement ops, err flags undefined opcodes.
module mp_alu_p
  import mp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]          op_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] result_o,
  output logic                     err_o
);

  // Average with one guard bit so the intermediate sum cannot overflow.
  function automatic logic signed [DATA_W-1:0] avg_f(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    return sum[DATA_W:1];
  endfunction

  // Opcode decode; undefined opcodes yield zero with err set.
  always_comb begin
    result_o = '0;
    err_o    = !is_defined_op(op_i);
    case (op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_MIN: result_o = (a_i < b_i) ? a_i : b_i;
      OP_AND: result_o = a_i & b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_MAX: result_o = (a_i > b_i) ? a_i : b_i;
      OP_NEG: result_o = -a_i;
      OP_AVG: result_o = avg_f(a_i, b_i);
      OP_ABS: result_o = a_i[DATA_W-1] ? -a_i : a_i;
      OP_NOT: result_o = ~a_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/mp_pipe.sv
// Two-stage register-to-register pipeline with S1->accept forwarding,
// backpressured result stream and a loader port into the register file.
module mp_pipe
  import mp_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  REG_COUNT = 32,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic [DATA_W-1:0] result,
  output logic              result_err,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int RS2_LSB   = rs2_lsb(ADDR_W);
  localparam int RD_LSB    = rd_lsb(ADDR_W);
  localparam int FIELD_END = field_end(ADDR_W);

  logic                     stall, accept, wb_en;
  logic [OP_W-1:0]          op_p0;
  logic [ADDR_W-1:0]        rs1_p0, rs2_p0, rd_p0;
  logic signed [DATA_W-1:0] a_p1_d, b_p1_d;

  logic                     vld_p1_q;
  logic [OP_W-1:0]          op_p1_q;
  logic [ADDR_W-1:0]        rd_p1_q;
  logic signed [DATA_W-1:0] a_p1_q, b_p1_q;
  logic signed [DATA_W-1:0] alu_res_p1;
  logic                     alu_err_p1;

  logic                     vld_p2_q;
  logic signed [DATA_W-1:0] res_p2_q;
  logic                     err_p2_q;
  logic [ADDR_W-1:0]        rd_p2_q;

  logic signed [DATA_W-1:0] rf_q [REG_COUNT];
  logic                     unused_bits;

  // ---- p0: decode and operand select at accept ----
  assign stall       = vld_p2_q && !result_ready;
  assign instr_ready = !stall && !rst;
  assign accept      = instr_valid && instr_ready;

  assign op_p0  = instr[OP_W-1:0];
  assign rs1_p0 = instr[RS1_LSB +: ADDR_W];
  assign rs2_p0 = instr[RS2_LSB +: ADDR_W];
  assign rd_p0  = instr[RD_LSB +: ADDR_W];

  // S1 commits to the register file when it is a defined op with rd != r0.
  assign wb_en = vld_p1_q && !alu_err_p1 && (rd_p1_q != '0);

  // Operand fetch: forward S1's ALU output over the register file, r0 is zero.
  always_comb begin
    a_p1_d = '0;
    b_p1_d = '0;
    if (wb_en && (rd_p1_q == rs1_p0)) a_p1_d = alu_res_p1;
    else if (rs1_p0 != '0)            a_p1_d = rf_q[rs1_p0];
    if (wb_en && (rd_p1_q == rs2_p0)) b_p1_d = alu_res_p1;
    else if (rs2_p0 != '0)            b_p1_d = rf_q[rs2_p0];
  end

  // ---- p1: latched opcode, rd and operands ----
  // S1 register: loads on accept, empties when it drains without new input.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      op_p1_q  <= '0;
      rd_p1_q  <= '0;
      a_p1_q   <= '0;
      b_p1_q   <= '0;
    end else if (!stall) begin
      vld_p1_q <= accept;
      if (accept) begin
        op_p1_q <= op_p0;
        rd_p1_q <= rd_p0;
        a_p1_q  <= a_p1_d;
        b_p1_q  <= b_p1_d;
      end
    end
  end

  mp_alu_p #(.DATA_W(DATA_W)) u_alu (
    .op_i     (op_p1_q),
    .a_i      (a_p1_q),
    .b_i      (b_p1_q),
    .result_o (alu_res_p1),
    .err_o    (alu_err_p1)
  );

  // ---- p2: result slot driving the output handshake ----
  // S2 register: takes S1 whenever the consumer is not holding the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
      err_p2_q <= 1'b0;
      rd_p2_q  <= '0;
    end else if (!stall) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        res_p2_q <= alu_res_p1;
        err_p2_q <= alu_err_p1;
        rd_p2_q  <= rd_p1_q;
      end
    end
  end

  assign result       = res_p2_q;
  assign result_err   = err_p2_q;
  assign result_valid = vld_p2_q;

  // Register file: loader write first so a same-edge pipeline write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      if (init_we && (init_addr != '0)) rf_q[init_addr] <= init_data;
      if (!stall && wb_en)              rf_q[rd_p1_q]   <= alu_res_p1;
    end
  end

  // rd in S2 is kept for visibility only; spare instruction bits are ignored.
  generate
    if (FIELD_END < 32) begin : g_spare
      assign unused_bits = ^{rd_p2_q, instr[31:FIELD_END]};
    end else begin : g_nospare
      assign unused_bits = ^rd_p2_q;
    end
  endgenerate

endmodule
